// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry controller: key codes,
// operation and state encodings, operand width and key decode helpers.
// Optional feature macro: CALC_MULT_EN (enables the MUL key and multiplier).
package calc_pkg;

  localparam int unsigned CALC_W = 16;

  // Key codes carried on key_val; 0x00-0x0F are hex digits.
  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_ENTER_A  = 2'd0,
    ST_ENTER_B  = 2'd1,
    ST_COMPUTE  = 2'd2,
    ST_SHOW_RES = 2'd3
  } state_e;

  // True for keys that select an operation. MUL only counts as an
  // operation key when the multiplier is built in; otherwise it is invalid.
  function automatic logic is_op_key(input logic [4:0] k);
    logic r;
    r = (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_AND) || (k == KEY_OR);
`ifdef CALC_MULT_EN
    r = r || (k == KEY_MUL);
`endif
    return r;
  endfunction

  // Maps an operation key to its op encoding (only meaningful when is_op_key).
  function automatic op_e key_to_op(input logic [4:0] k);
    op_e r;
    case (k)
      KEY_SUB: r = OP_SUB;
      KEY_MUL: r = OP_MUL;
      KEY_AND: r = OP_AND;
      KEY_OR:  r = OP_OR;
      default: r = OP_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational 16-bit ALU for the calculator: ADD, SUB, AND, OR and,
// when CALC_MULT_EN is defined, MUL. Overflow reports carry, borrow or
// a non-zero upper product half; logic ops never overflow.
module calc_alu
  import calc_pkg::*;
(
  input  logic [CALC_W-1:0] a,
  input  logic [CALC_W-1:0] b,
  input  logic [2:0]        op,
  output logic [CALC_W-1:0] result,
  output logic              overflow
);

  logic [CALC_W:0] w_sum;
  assign w_sum = {1'b0, a} + {1'b0, b};

`ifdef CALC_MULT_EN
  logic [2*CALC_W-1:0] w_prod;
  assign w_prod = a * b;
`endif

  // Select the result and overflow flag for the latched operation.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = w_sum[CALC_W-1:0];
        overflow = w_sum[CALC_W];
      end
      OP_SUB: begin
        result   = a - b;
        overflow = (a < b);
      end
`ifdef CALC_MULT_EN
      OP_MUL: begin
        result   = w_prod[CALC_W-1:0];
        overflow = |w_prod[2*CALC_W-1:CALC_W];
      end
`endif
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator key-entry controller: collects operand A, an operation and
// operand B from a key stream, computes through calc_alu, shows the result
// and supports chaining, CE and CLR.
// Optional feature macro: CALC_MULT_EN (MUL key; otherwise 0x11 is invalid).
//
// Key interface: key_valid is a one-cycle strobe with no back-pressure; the
// controller samples key_val on every rising edge where key_valid=1 and
// never stalls the source. Keys that are invalid, or not meaningful in the
// current state (including everything during COMPUTE), are dropped.
module calc_entry_ctrl
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_val,
  output logic        restriction,
  output logic [15:0] display,
  output logic [2:0]  op,
  output logic        busy,
  output logic        result_valid,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  state_e             r_state;
  logic [CALC_W-1:0]  r_a;
  logic [CALC_W-1:0]  r_b;
  logic [CALC_W-1:0]  r_result;
  logic [2:0]         r_cnt_a;
  logic [2:0]         r_cnt_b;
  op_e                r_op;
  logic               r_overflow;
  logic               r_result_valid;

  logic               w_is_digit;
  logic               w_is_op;
  logic               w_clear;
  logic [3:0]         w_digit;
  logic [CALC_W-1:0]  w_alu_result;
  logic               w_alu_overflow;

  assign w_is_digit = key_valid && (key_val[4] == 1'b0);
  assign w_is_op    = key_valid && is_op_key(key_val);
  assign w_digit    = key_val[3:0];

  // CLR anywhere but COMPUTE, and CE while a result is shown, restart entry.
  assign w_clear = key_valid && (r_state != ST_COMPUTE) &&
                   ((key_val == KEY_CLR) ||
                    ((key_val == KEY_CE) && (r_state == ST_SHOW_RES)));

  calc_alu u_alu (
    .a        (r_a),
    .b        (r_b),
    .op       (r_op),
    .result   (w_alu_result),
    .overflow (w_alu_overflow)
  );

  // Entry FSM and datapath registers; reset and clear share one path.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_state        <= ST_ENTER_A;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_cnt_a        <= 3'd0;
      r_cnt_b        <= 3'd0;
      r_op           <= OP_ADD;
      r_overflow     <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_ENTER_A: begin
          if (w_is_digit) begin
            if (r_cnt_a < 3'd4) begin
              r_a     <= {r_a[11:0], w_digit};
              r_cnt_a <= r_cnt_a + 3'd1;
            end
          end else if (w_is_op) begin
            r_op    <= key_to_op(key_val);
            r_b     <= '0;
            r_cnt_b <= 3'd0;
            r_state <= ST_ENTER_B;
          end else if (key_valid && (key_val == KEY_CE)) begin
            r_a     <= '0;
            r_cnt_a <= 3'd0;
          end
        end
        ST_ENTER_B: begin
          if (w_is_digit) begin
            if (r_cnt_b < 3'd4) begin
              r_b     <= {r_b[11:0], w_digit};
              r_cnt_b <= r_cnt_b + 3'd1;
            end
          end else if (w_is_op) begin
            r_op <= key_to_op(key_val);
          end else if (key_valid && (key_val == KEY_EXE)) begin
            r_state <= ST_COMPUTE;
          end else if (key_valid && (key_val == KEY_CE)) begin
            r_b     <= '0;
            r_cnt_b <= 3'd0;
          end
        end
        ST_COMPUTE: begin
          r_result       <= w_alu_result;
          r_overflow     <= w_alu_overflow;
          r_result_valid <= 1'b1;
          r_state        <= ST_SHOW_RES;
        end
        ST_SHOW_RES: begin
          if (w_is_op) begin
            r_a     <= r_result;
            r_op    <= key_to_op(key_val);
            r_b     <= '0;
            r_cnt_b <= 3'd0;
            r_state <= ST_ENTER_B;
          end
        end
        default: r_state <= ST_ENTER_A;
      endcase
    end
  end

  // Show the operand being entered, otherwise the registered result.
  always_comb begin
    case (r_state)
      ST_ENTER_A: display = r_a;
      ST_ENTER_B: display = r_b;
      default:    display = r_result;
    endcase
  end

  assign restriction  = (r_state == ST_COMPUTE) || (r_state == ST_SHOW_RES);
  assign busy         = (r_state == ST_COMPUTE);
  assign op           = r_op;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl. Inputs change on the falling edge;
// outputs are checked on the falling edge after the rising edge that used them.
module tb_calc_entry_ctrl;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  localparam logic [1:0] S_A = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_C = 2'd2;
  localparam logic [1:0] S_R = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_val = 5'h00;
  logic        restriction;
  logic [15:0] display;
  logic [2:0]  op;
  logic        busy;
  logic        result_valid;
  logic        overflow;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  calc_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_val      (key_val),
    .restriction  (restriction),
    .display      (display),
    .op           (op),
    .busy         (busy),
    .result_valid (result_valid),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic press(input logic [4:0] k);
    key_valid = 1'b1;
    key_val   = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_val   = 5'h00;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (dbg_state !== S_A) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_A); end
    n_cmp++; if (display !== 16'h0000) begin n_mis++; $display("FAIL reset_display: got %h want 0000", display); end
    n_cmp++; if (op !== 3'd0) begin n_mis++; $display("FAIL reset_op: got %0d want 0", op); end
    n_cmp++; if ({busy, result_valid, overflow, restriction} !== 4'b0000) begin n_mis++; $display("FAIL reset_flags: got %b want 0000", {busy, result_valid, overflow, restriction}); end
  endtask

  task automatic test_basic_add();
    press(5'h1); press(5'h2);
    n_cmp++; if (display !== 16'h0012) begin n_mis++; $display("FAIL add_a_entry: got %h want 0012", display); end
    press(5'h1F);
    n_cmp++; if ({dbg_state, display} !== {S_A, 16'h0012}) begin n_mis++; $display("FAIL invalid_key_a: got %h want %h", {dbg_state, display}, {S_A, 16'h0012}); end
    press(K_ADD);
    n_cmp++; if ({dbg_state, display} !== {S_B, 16'h0000}) begin n_mis++; $display("FAIL add_enter_b: got %h want %h", {dbg_state, display}, {S_B, 16'h0000}); end
    press(5'h3);
    n_cmp++; if (display !== 16'h0003) begin n_mis++; $display("FAIL add_b_entry: got %h want 0003", display); end
    press(K_EXE);
    n_cmp++; if ({dbg_state, busy, restriction, result_valid} !== {S_C, 3'b110}) begin n_mis++; $display("FAIL add_compute: got %b want %b", {dbg_state, busy, restriction, result_valid}, {S_C, 3'b110}); end
    idle();
    n_cmp++; if ({result_valid, display} !== {1'b1, 16'h0015}) begin n_mis++; $display("FAIL add_result: got %h want %h", {result_valid, display}, {1'b1, 16'h0015}); end
    n_cmp++; if ({dbg_state, overflow, restriction, busy} !== {S_R, 3'b010}) begin n_mis++; $display("FAIL add_show: got %b want %b", {dbg_state, overflow, restriction, busy}, {S_R, 3'b010}); end
    idle();
    n_cmp++; if (result_valid !== 1'b0) begin n_mis++; $display("FAIL add_rv_pulse: got %b want 0", result_valid); end
  endtask

  task automatic test_overflow();
    press(K_CLR);
    press(5'hF); press(5'hF); press(5'hF); press(5'hF);
    press(K_ADD); press(5'h2); press(K_EXE); idle();
    n_cmp++; if ({overflow, display} !== {1'b1, 16'h0001}) begin n_mis++; $display("FAIL add_carry: got %h want %h", {overflow, display}, {1'b1, 16'h0001}); end
    press(K_SUB);
    n_cmp++; if ({dbg_state, op, display} !== {S_B, 3'd1, 16'h0000}) begin n_mis++; $display("FAIL chain_sub: got %h want %h", {dbg_state, op, display}, {S_B, 3'd1, 16'h0000}); end
    press(5'h5); press(K_EXE); idle();
    n_cmp++; if ({result_valid, overflow, display} !== {2'b11, 16'hFFFC}) begin n_mis++; $display("FAIL sub_borrow: got %h want %h", {result_valid, overflow, display}, {2'b11, 16'hFFFC}); end
  endtask

  task automatic test_digit_limit();
    press(K_CLR);
    n_cmp++; if ({dbg_state, display, overflow} !== {S_A, 16'h0000, 1'b0}) begin n_mis++; $display("FAIL clr_state: got %h want %h", {dbg_state, display, overflow}, {S_A, 16'h0000, 1'b0}); end
    press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
    n_cmp++; if (display !== 16'h1234) begin n_mis++; $display("FAIL fifth_digit: got %h want 1234", display); end
    press(K_CE);
    n_cmp++; if ({dbg_state, display} !== {S_A, 16'h0000}) begin n_mis++; $display("FAIL ce_a: got %h want %h", {dbg_state, display}, {S_A, 16'h0000}); end
    press(5'h7);
    n_cmp++; if (display !== 16'h0007) begin n_mis++; $display("FAIL ce_a_count: got %h want 0007", display); end
  endtask

  task automatic test_op_replace_ce_b();
    press(K_CLR);
    press(5'h9); press(K_ADD); press(5'h3); press(K_SUB);
    n_cmp++; if ({dbg_state, op, display} !== {S_B, 3'd1, 16'h0003}) begin n_mis++; $display("FAIL op_replace: got %h want %h", {dbg_state, op, display}, {S_B, 3'd1, 16'h0003}); end
    press(K_EXE); idle();
    n_cmp++; if ({overflow, display} !== {1'b0, 16'h0006}) begin n_mis++; $display("FAIL replace_result: got %h want %h", {overflow, display}, {1'b0, 16'h0006}); end
    press(K_CLR);
    press(5'h9); press(K_SUB); press(5'h3); press(K_CE);
    n_cmp++; if ({dbg_state, display} !== {S_B, 16'h0000}) begin n_mis++; $display("FAIL ce_b: got %h want %h", {dbg_state, display}, {S_B, 16'h0000}); end
    press(K_EXE); idle();
    n_cmp++; if (display !== 16'h0009) begin n_mis++; $display("FAIL ce_b_result: got %h want 0009", display); end
  endtask

  task automatic test_mul();
    press(K_CLR);
    press(5'h1); press(5'h0); press(5'h0); press(K_MUL);
`ifdef CALC_MULT_EN
    n_cmp++; if ({dbg_state, op} !== {S_B, 3'd2}) begin n_mis++; $display("FAIL mul_latch: got %h want %h", {dbg_state, op}, {S_B, 3'd2}); end
    press(5'h1); press(5'h0); press(5'h0); press(K_EXE); idle();
    n_cmp++; if ({overflow, display} !== {1'b1, 16'h0000}) begin n_mis++; $display("FAIL mul_ovf: got %h want %h", {overflow, display}, {1'b1, 16'h0000}); end
`else
    n_cmp++; if ({dbg_state, op, display} !== {S_A, 3'd0, 16'h0100}) begin n_mis++; $display("FAIL mul_ignored: got %h want %h", {dbg_state, op, display}, {S_A, 3'd0, 16'h0100}); end
    press(K_EXE);
    n_cmp++; if (dbg_state !== S_A) begin n_mis++; $display("FAIL mul_exe_a: got %0d want %0d", dbg_state, S_A); end
`endif
  endtask

  task automatic test_show_res();
    press(K_CLR);
    press(5'h2); press(K_ADD); press(5'h3); press(K_EXE); idle();
    press(5'h7);
    n_cmp++; if ({dbg_state, display, result_valid} !== {S_R, 16'h0005, 1'b0}) begin n_mis++; $display("FAIL show_digit: got %h want %h", {dbg_state, display, result_valid}, {S_R, 16'h0005, 1'b0}); end
    press(K_EXE);
    n_cmp++; if ({dbg_state, result_valid} !== {S_R, 1'b0}) begin n_mis++; $display("FAIL show_exe: got %b want %b", {dbg_state, result_valid}, {S_R, 1'b0}); end
    press(K_SUB); press(5'h1); press(K_EXE);
    press(K_CLR);
    n_cmp++; if ({dbg_state, result_valid, display} !== {S_R, 1'b1, 16'h0004}) begin n_mis++; $display("FAIL compute_ignores_clr: got %h want %h", {dbg_state, result_valid, display}, {S_R, 1'b1, 16'h0004}); end
    press(K_CE);
    n_cmp++; if ({dbg_state, op, display, restriction} !== {S_A, 3'd0, 16'h0000, 1'b0}) begin n_mis++; $display("FAIL ce_in_show: got %h want %h", {dbg_state, op, display, restriction}, {S_A, 3'd0, 16'h0000, 1'b0}); end
  endtask

  task automatic test_rst_priority();
    press(K_CLR);
    press(5'h1); press(5'h2);
    rst = 1'b1; key_valid = 1'b1; key_val = 5'h9;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; key_val = 5'h00;
    n_cmp++; if ({dbg_state, display} !== {S_A, 16'h0000}) begin n_mis++; $display("FAIL rst_over_key: got %h want %h", {dbg_state, display}, {S_A, 16'h0000}); end
    press(5'h4); press(K_SUB); press(5'h9); press(K_EXE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({dbg_state, result_valid, busy, overflow, restriction} !== {S_A, 4'b0000}) begin n_mis++; $display("FAIL rst_in_compute: got %b want %b", {dbg_state, result_valid, busy, overflow, restriction}, {S_A, 4'b0000}); end
    n_cmp++; if ({op, display} !== {3'd0, 16'h0000}) begin n_mis++; $display("FAIL rst_compute_vals: got %h want %h", {op, display}, {3'd0, 16'h0000}); end
    idle();
    n_cmp++; if ({dbg_state, result_valid} !== {S_A, 1'b0}) begin n_mis++; $display("FAIL rst_no_pulse: got %b want %b", {dbg_state, result_valid}, {S_A, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_overflow();
    test_digit_limit();
    test_op_replace_ce_b();
    test_mul();
    test_show_res();
    test_rst_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
